// File: rtl/ibex_branch_predict_bht.sv
// Dynamic branch predictor for the IF stage: decodes jumps/branches, computes the
// target and predicts conditional branches from a PC-indexed table of saturating counters.
module ibex_branch_predict_bht #(
    parameter int unsigned BhtEntries = 64,
    parameter int unsigned CntWidth   = 2,
    parameter int unsigned CntInit    = 2**(CntWidth-1)-1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [31:0] fetch_rdata_i,
    input  logic [31:0] fetch_pc_i,
    input  logic        fetch_valid_i,
    output logic        predict_branch_taken_o,
    output logic [31:0] predict_branch_pc_o,
    output logic        predict_dynamic_o,
    input  logic        update_valid_i,
    input  logic [31:0] update_pc_i,
    input  logic        update_taken_i,
    output logic        init_done_o
);

    localparam int unsigned IdxW = $clog2(BhtEntries);
    localparam logic [IdxW-1:0]     IdxMax   = IdxW'(BhtEntries - 1);
    localparam logic [CntWidth-1:0] CntMax   = {CntWidth{1'b1}};
    localparam logic [CntWidth-1:0] CntInitW = CntWidth'(CntInit);
    localparam logic [6:0]          OpJal    = 7'h6f;
    localparam logic [6:0]          OpBranch = 7'h63;

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [CntWidth-1:0] bht_q [BhtEntries];

    logic                wr_en;
    logic [IdxW-1:0]     wr_idx;
    logic [CntWidth-1:0] wr_data;

    logic        instr_j, instr_b, instr_cj, instr_cb, cond, dir;
    logic [31:0] imm_j, imm_b, imm_cj, imm_cb, imm;
    logic [IdxW-1:0]     lookup_idx, upd_idx;
    logic [CntWidth-1:0] cnt_rd, cnt_upd;

    // Decode
    assign instr_j  = (fetch_rdata_i[6:0] == OpJal);
    assign instr_b  = (fetch_rdata_i[6:0] == OpBranch);
    // C.J (101) and C.JAL (001, RV32 only) in quadrant 1
    assign instr_cj = (fetch_rdata_i[1:0] == 2'b01) &&
                      ((fetch_rdata_i[15:13] == 3'b101) || (fetch_rdata_i[15:13] == 3'b001));
    // C.BEQZ (110) and C.BNEZ (111)
    assign instr_cb = (fetch_rdata_i[1:0] == 2'b01) && (fetch_rdata_i[15:14] == 2'b11);
    assign cond     = instr_b | instr_cb;

    assign imm_j  = {{12{fetch_rdata_i[31]}}, fetch_rdata_i[19:12], fetch_rdata_i[20],
                     fetch_rdata_i[30:21], 1'b0};
    assign imm_b  = {{20{fetch_rdata_i[31]}}, fetch_rdata_i[7], fetch_rdata_i[30:25],
                     fetch_rdata_i[11:8], 1'b0};
    assign imm_cj = {{21{fetch_rdata_i[12]}}, fetch_rdata_i[8], fetch_rdata_i[10:9],
                     fetch_rdata_i[6], fetch_rdata_i[7], fetch_rdata_i[2], fetch_rdata_i[11],
                     fetch_rdata_i[5:3], 1'b0};
    assign imm_cb = {{24{fetch_rdata_i[12]}}, fetch_rdata_i[6:5], fetch_rdata_i[2],
                     fetch_rdata_i[11:10], fetch_rdata_i[4:3], 1'b0};

    always_comb begin
        imm = imm_b;
        if (instr_j) begin
            imm = imm_j;
        end else if (instr_cj) begin
            imm = imm_cj;
        end else if (instr_cb) begin
            imm = imm_cb;
        end
    end

    assign predict_branch_pc_o = fetch_pc_i + imm;

    // Lookup and update share halfword-granular indexing
    assign lookup_idx = fetch_pc_i[IdxW:1];
    assign upd_idx    = update_pc_i[IdxW:1];
    assign cnt_rd     = bht_q[lookup_idx];
    assign cnt_upd    = bht_q[upd_idx];

    // Static backward-taken rule until the table has been swept
    assign dir = (state_q == StRun) ? cnt_rd[CntWidth-1] : imm[31];

    assign init_done_o            = (state_q == StRun);
    assign predict_branch_taken_o = fetch_valid_i & (instr_j | instr_cj | (cond & dir));
    assign predict_dynamic_o      = fetch_valid_i & cond & init_done_o;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        wr_idx  = idx_q;
        wr_data = CntInitW;
        if (flush_i) begin
            state_d = StInit;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                StInit: begin
                    wr_en = 1'b1;
                    idx_d = idx_q + IdxW'(1);
                    if (idx_q == IdxMax) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (update_valid_i) begin
                        wr_en  = 1'b1;
                        wr_idx = upd_idx;
                        if (update_taken_i) begin
                            wr_data = (cnt_upd == CntMax) ? CntMax : cnt_upd + CntWidth'(1);
                        end else begin
                            wr_data = (cnt_upd == '0) ? '0 : cnt_upd - CntWidth'(1);
                        end
                    end
                end
                default: state_d = StInit;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StInit;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Counter array has no reset; the init sweep gives it defined contents
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            bht_q[wr_idx] <= wr_data;
        end
    end

    logic unused_update_pc;
    assign unused_update_pc = ^{update_pc_i[31:IdxW+1], update_pc_i[0]};

`ifndef SYNTHESIS
    assert property (@(posedge clk_i) disable iff (rst_i)
        fetch_valid_i |-> $onehot0({instr_j, instr_b, instr_cj, instr_cb}));
`endif

endmodule

// File: tb/tb_ibex_branch_predict_bht.sv
// Directed bench for ibex_branch_predict_bht with hand-computed expectations.
module tb_ibex_branch_predict_bht;

    localparam logic [31:0] BeqM8   = 32'hFE000CE3;  // beq x0,x0,-8
    localparam logic [31:0] BeqP8   = 32'h00000463;  // beq x0,x0,+8
    localparam logic [31:0] BneP16  = 32'h00001863;  // bne x0,x0,+16
    localparam logic [31:0] JalM4   = 32'hFFDFF06F;  // jal x0,-4
    localparam logic [31:0] CjP2    = 32'h0000A009;  // c.j +2
    localparam logic [31:0] CbnezM2 = 32'h0000FC7D;  // c.bnez x8,-2
    localparam logic [31:0] Addi    = 32'h00000013;  // nop

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] fetch_rdata;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic        taken;
    logic [31:0] target;
    logic        dynamic;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic        init_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start;
    int cycles;

    always #5 clk = ~clk;

    ibex_branch_predict_bht dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .flush_i               (flush),
        .fetch_rdata_i         (fetch_rdata),
        .fetch_pc_i            (fetch_pc),
        .fetch_valid_i         (fetch_valid),
        .predict_branch_taken_o(taken),
        .predict_branch_pc_o   (target),
        .predict_dynamic_o     (dynamic),
        .update_valid_i        (update_valid),
        .update_pc_i           (update_pc),
        .update_taken_i        (update_taken),
        .init_done_o           (init_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic fetch(input logic [31:0] instr, input logic [31:0] pc);
        fetch_rdata = instr;
        fetch_pc    = pc;
        fetch_valid = 1'b1;
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk);
        update_valid = 1'b1;
        update_pc    = pc;
        update_taken = tk;
        tick();
        update_valid = 1'b0;
        #1;
    endtask

    task automatic wait_init();
        for (int i = 0; i < 200 && !init_done; i++) begin
            tick();
        end
    endtask

    initial begin
        rst          = 1'b1;
        flush        = 1'b0;
        fetch_rdata  = BeqM8;
        fetch_pc     = 32'h100;
        fetch_valid  = 1'b0;
        update_valid = 1'b0;
        update_pc    = '0;
        update_taken = 1'b0;
        tick();
        tick();
        check_eq("rst_init_done", 32'(init_done), 0);
        check_eq("rst_taken", 32'(taken), 0);
        check_eq("rst_dynamic", 32'(dynamic), 0);
        rst   = 1'b0;
        start = cyc;

        // Static rule while sweeping
        tick();
        tick();
        tick();
        check_eq("init_busy", 32'(init_done), 0);
        fetch(BeqM8, 32'h100);
        check_eq("static_bwd_taken", 32'(taken), 1);
        check_eq("static_bwd_pc", target, 32'hF8);
        check_eq("static_bwd_dyn", 32'(dynamic), 0);
        fetch(BeqP8, 32'h100);
        check_eq("static_fwd_taken", 32'(taken), 0);
        fetch(CbnezM2, 32'h100);
        check_eq("static_cb_taken", 32'(taken), 1);
        check_eq("static_cb_pc", target, 32'hFE);
        upd(32'h200, 1'b1);
        upd(32'h200, 1'b1);
        fetch_valid = 1'b0;
        wait_init();
        check_eq("init_cycles", 32'(cyc - start), 64);

        // Entry 0 must hold CntInit despite the updates issued during INIT
        fetch(BneP16, 32'h200);
        check_eq("bne_init_taken", 32'(taken), 0);
        check_eq("bne_init_dyn", 32'(dynamic), 1);
        check_eq("bne_init_pc", target, 32'h210);
        upd(32'h200, 1'b1);
        upd(32'h200, 1'b1);
        check_eq("cnt3_taken", 32'(taken), 1);
        upd(32'h200, 1'b0);
        check_eq("cnt2_taken", 32'(taken), 1);
        upd(32'h200, 1'b0);
        check_eq("cnt1_taken", 32'(taken), 0);
        upd(32'h200, 1'b0);
        upd(32'h200, 1'b0);
        upd(32'h200, 1'b1);
        check_eq("sat_low_taken", 32'(taken), 0);

        fetch_valid = 1'b0;
        #1;
        check_eq("idle_taken", 32'(taken), 0);
        check_eq("idle_dyn", 32'(dynamic), 0);

        fetch(JalM4, 32'h0);
        check_eq("jal_taken", 32'(taken), 1);
        check_eq("jal_pc", target, 32'hFFFFFFFC);
        check_eq("jal_dyn", 32'(dynamic), 0);
        fetch(CjP2, 32'h40);
        check_eq("cj_taken", 32'(taken), 1);
        check_eq("cj_pc", target, 32'h42);
        fetch(Addi, 32'h44);
        check_eq("alu_taken", 32'(taken), 0);
        check_eq("alu_dyn", 32'(dynamic), 0);
        tick();
        fetch(BneP16, 32'h200);
        check_eq("table_kept", 32'(taken), 0);

        // Aliasing: 0x280 shares entry 0 with 0x200; 0x202 uses entry 1
        upd(32'h200, 1'b1);
        upd(32'h200, 1'b1);
        fetch(BneP16, 32'h280);
        check_eq("alias_taken", 32'(taken), 1);
        fetch(BneP16, 32'h202);
        check_eq("adjacent_taken", 32'(taken), 0);
        upd(32'h200, 1'b1);
        upd(32'h200, 1'b0);
        fetch(BneP16, 32'h280);
        check_eq("sat_high_taken", 32'(taken), 1);

        // Flush from RUN, then again 30 cycles into the sweep with a coincident update
        fetch_valid = 1'b0;
        flush       = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush_done_low", 32'(init_done), 0);
        for (int i = 0; i < 29; i++) begin
            tick();
        end
        flush        = 1'b1;
        update_valid = 1'b1;
        update_pc    = 32'h300;
        update_taken = 1'b1;
        tick();
        flush        = 1'b0;
        update_valid = 1'b0;
        start        = cyc;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        upd(32'h300, 1'b1);
        wait_init();
        check_eq("flush_cycles", 32'(cyc - start), 64);
        fetch(BneP16, 32'h300);
        check_eq("flush_entry_taken", 32'(taken), 0);
        check_eq("flush_entry_dyn", 32'(dynamic), 1);

        // Same-cycle update and lookup: no bypass
        update_valid = 1'b1;
        update_pc    = 32'h300;
        update_taken = 1'b1;
        #1;
        check_eq("same_cycle_taken", 32'(taken), 0);
        tick();
        update_valid = 1'b0;
        #1;
        check_eq("next_cycle_taken", 32'(taken), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
